// File: rtl/imem_responder_if.sv
// Fetch request/response handshake between the IF stage
// and the instruction-memory responder.
interface imem_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_fault;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_instr,
    input  rsp_addr,
    input  rsp_fault
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_instr,
    output rsp_addr,
    output rsp_fault
  );
endinterface

// File: rtl/imem_responder.sv
// Word-addressed instruction store answering fetch requests
// after WAIT_STATES cycles, with flush cancel and a load port.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               reset,
  imem_responder_if.slave    bus,
  input  logic               flush,
  input  logic               load_we,
  input  logic [31:0]        load_addr,
  input  logic [31:0]        load_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          load_ok;
  logic [AW-1:0] load_idx;
  logic [31:0]   cap_addr;
  logic [AW-1:0] cap_idx;
  logic          cap_fault;
  logic [31:0]   cap_word;
  logic [31:0]   cap_instr;
  logic          unused_load_lsb;

  assign bus.req_ready = !reset && !flush &&
    (state == IDLE ||
     (state == RESP && bus.rsp_ready));

  assign accept   = bus.req_valid && bus.req_ready;
  assign load_ok  = load_we &&
    (load_addr[31:AW+2] == '0);
  assign load_idx = load_addr[AW+1:2];
  assign unused_load_lsb = ^load_addr[1:0];

  // Zero-wait accepts read straight off the request bus.
  assign cap_addr  = (state == WAIT) ? addr_q
                                     : bus.req_addr;
  assign cap_idx   = cap_addr[AW+1:2];
  assign cap_fault = (cap_addr[1:0] != 2'b00) ||
    (cap_addr[31:AW+2] != '0);
  assign cap_word  =
    (load_ok && load_idx == cap_idx) ? load_data
                                     : mem[cap_idx];
  assign cap_instr = cap_fault ? NOP : cap_word;

  always_ff @(posedge clk) begin
    if (load_ok) mem[load_idx] <= load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      addr_q        <= 32'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_instr <= NOP;
      bus.rsp_addr  <= 32'd0;
      bus.rsp_fault <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.rsp_valid <= 1'b0;
    end else if (accept) begin
      addr_q <= bus.req_addr;
      cnt    <= WS;
      if (WS == 4'd0) begin
        state         <= RESP;
        bus.rsp_valid <= 1'b1;
        bus.rsp_instr <= cap_instr;
        bus.rsp_addr  <= bus.req_addr;
        bus.rsp_fault <= cap_fault;
      end else begin
        state         <= WAIT;
        bus.rsp_valid <= 1'b0;
      end
    end else begin
      unique case (state)
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_instr <= cap_instr;
            bus.rsp_addr  <= addr_q;
            bus.rsp_fault <= cap_fault;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench: two responders (2 and 0 wait states)
// share stimulus and are checked against a transaction model.
module tb_imem_responder;
  localparam int D = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        flush;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  imem_responder_if bus0 ();
  imem_responder_if bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_addr  = req_addr;
  assign bus0.rsp_ready = rsp_ready;
  assign bus1.req_valid = req_valid;
  assign bus1.req_addr  = req_addr;
  assign bus1.rsp_ready = rsp_ready;

  imem_responder #(
    .DEPTH_WORDS(D),
    .WAIT_STATES(2)
  ) u_ws2 (
    .clk(clk),
    .reset(reset),
    .bus(bus0),
    .flush(flush),
    .load_we(load_we),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  imem_responder #(
    .DEPTH_WORDS(D),
    .WAIT_STATES(0)
  ) u_ws0 (
    .clk(clk),
    .reset(reset),
    .bus(bus1),
    .flush(flush),
    .load_we(load_we),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem_m [D];
  bit          busy [2];
  logic [31:0] paddr [2];
  int          due [2];
  logic [31:0] cap_i [2];
  logic [31:0] cap_a [2];
  logic        cap_f [2];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int ws(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // One cycle: check outputs, advance model across the edge.
  task automatic step();
    logic        o_v, o_r, o_f;
    logic [31:0] o_i, o_a;
    bit          pres [2];
    bit          er [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o_v = bus0.rsp_valid; o_r = bus0.req_ready;
        o_f = bus0.rsp_fault; o_i = bus0.rsp_instr;
        o_a = bus0.rsp_addr;
      end else begin
        o_v = bus1.rsp_valid; o_r = bus1.req_ready;
        o_f = bus1.rsp_fault; o_i = bus1.rsp_instr;
        o_a = bus1.rsp_addr;
      end
      pres[k] = !reset && busy[k] && cyc >= due[k];
      er[k] = !reset && !flush &&
        (!busy[k] || (pres[k] && rsp_ready));
      check($sformatf("ready%0d", k), o_r, er[k]);
      check($sformatf("valid%0d", k), o_v, pres[k]);
      if (pres[k]) begin
        check($sformatf("instr%0d", k), o_i, cap_i[k]);
        check($sformatf("addr%0d", k), o_a, cap_a[k]);
        check($sformatf("fault%0d", k), o_f, cap_f[k]);
      end else if (reset) begin
        check($sformatf("rst_instr%0d", k), o_i, NOP);
        check($sformatf("rst_addr%0d", k), o_a, 0);
        check($sformatf("rst_fault%0d", k), o_f, 0);
      end
    end
    if (load_we && load_addr < 32'(4 * D))
      mem_m[load_addr >> 2] = load_data;
    for (int k = 0; k < 2; k++) begin
      if (reset || flush) begin
        busy[k] = 1'b0;
      end else begin
        if (pres[k] && rsp_ready) busy[k] = 1'b0;
        if (req_valid && er[k]) begin
          busy[k]  = 1'b1;
          paddr[k] = req_addr;
          due[k]   = cyc + 1 + ws(k);
        end
      end
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (busy[k] && cyc == due[k]) begin
        cap_a[k] = paddr[k];
        cap_f[k] = (paddr[k][1:0] != 2'b00) ||
          (paddr[k] >= 32'(4 * D));
        cap_i[k] = cap_f[k] ? NOP
                            : mem_m[paddr[k] >> 2];
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    flush     = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0;
    rsp_ready = 1'b1; flush = 1'b0; load_we = 1'b0;
    load_addr = '0; load_data = '0;
    @(negedge clk);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < D; i++) begin
      load_we   = 1'b1;
      load_addr = 32'(i * 4);
      load_data = (i == 0) ? 32'hAAAA_0001 :
                  (i == 1) ? 32'hBBBB_0002 : $urandom;
      step();
    end
    load_we = 1'b0;
    idle(1);

    // Latency with 2 and 0 wait states.
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    check("lat0_valid", bus1.rsp_valid, 1);
    check("lat0_instr", bus1.rsp_instr, 32'hBBBB_0002);
    check("lat2_early", bus0.rsp_valid, 0);
    step(); step();
    check("lat2_valid", bus0.rsp_valid, 1);
    check("lat2_instr", bus0.rsp_instr, 32'hBBBB_0002);
    check("lat2_addr", bus0.rsp_addr, 32'h4);
    check("lat2_fault", bus0.rsp_fault, 0);
    idle(3);

    // Back-to-back zero-wait fetches.
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      step();
      check("b2b_valid", bus1.rsp_valid, 1);
      check("b2b_instr", bus1.rsp_instr, mem_m[i]);
    end
    check("b2b_first", mem_m[0], 32'hAAAA_0001);
    idle(5);

    // Misaligned and out-of-range fetches.
    req_valid = 1'b1; req_addr = 32'h2;
    step();
    req_valid = 1'b0;
    step(); step();
    check("mis_fault", bus0.rsp_fault, 1);
    check("mis_instr", bus0.rsp_instr, NOP);
    step();
    req_valid = 1'b1; req_addr = 32'(4 * D);
    step();
    req_valid = 1'b0;
    step(); step();
    check("oor_fault", bus0.rsp_fault, 1);
    check("oor_instr", bus0.rsp_instr, NOP);
    idle(3);

    // Backpressure with a pending next request.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'hC;
    step();
    req_addr = 32'h10;
    for (int i = 0; i < 7; i++) step();
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("bp_next_valid", bus1.rsp_valid, 1);
    check("bp_next_addr", bus1.rsp_addr, 32'h10);
    idle(5);

    // Flush one cycle after accept, colliding request.
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    flush = 1'b1; req_addr = 32'h8;
    step();
    check("fl_valid2", bus0.rsp_valid, 0);
    check("fl_valid0", bus1.rsp_valid, 0);
    flush = 1'b0;
    step();
    req_valid = 1'b0;
    check("fl_retry_addr", bus1.rsp_addr, 32'h8);
    idle(5);

    // Reset in the middle of a wait.
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("mrst_valid", bus0.rsp_valid, 0);
    check("mrst_instr", bus0.rsp_instr, NOP);
    reset = 1'b0;
    step();
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    step(); step();
    check("mrst_mem", bus0.rsp_instr, 32'hBBBB_0002);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      req_valid = ($urandom_range(0, 9) < 6);
      if (kind < 7)
        req_addr = 32'($urandom_range(0, D - 1)) << 2;
      else if (kind == 7)
        req_addr = (32'($urandom_range(0, D - 1)) << 2) |
                   32'($urandom_range(1, 3));
      else if (kind == 8)
        req_addr = $urandom;
      else
        req_addr = 32'(4 * D);
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      load_we   = ($urandom_range(0, 4) == 0);
      load_addr = ($urandom_range(0, 7) == 0) ? $urandom :
        32'($urandom_range(0, 4 * D - 1));
      load_data = $urandom;
      step();
    end
    load_we = 1'b0;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that services the fetch stage's instruction requests over a valid/ready handshake with a configurable number of wait states. It sits between the IF stage (initiator) and a word-addressed instruction store. It also provides a side write port for program loading, and a flush input so a taken branch from EX can cancel an in-flight fetch.

## Interface
- DEPTH_WORDS, 256: number of 32-bit instruction words stored; power of two, ≥ 4.
- WAIT_STATES, 2: extra cycles between request acceptance and response; 0 to 15.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_addr  input  32  byte address of the requested instruction (PCF).
- req_ready  output  1  responder can accept a request this cycle.
- flush  input  1  cancel any pending or presented response (PCSrcE redirect).
- rsp_valid  output  1  response holding valid data.
- rsp_ready  input  1  fetch stage consumes the response this cycle.
- rsp_instr  output  32  instruction word.
- rsp_addr  output  32  byte address the response belongs to.
- rsp_fault  output  1  request was misaligned or out of range.
- load_we  input  1  program-load write enable.
- load_addr  input  32  byte address for the load write.
- load_data  input  32  word to write.

## Operation
- FSM states: IDLE, WAIT, RESP.
- req_ready = !reset && !flush && (state==IDLE || (state==RESP && rsp_ready)). This is combinational.
- Accept = req_valid && req_ready at a rising edge. On accept, latch req_addr and load the wait counter with WAIT_STATES.
  - If WAIT_STATES==0, go directly to RESP.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each edge. On the edge where the counter is 1, go to RESP.
- Response data is captured on the edge that enters RESP:
  - Index = addr[log2(DEPTH_WORDS)+1:2].
  - fault = (addr[1:0]!=0) || (addr ≥ 4*DEPTH_WORDS).
  - On fault, rsp_instr = 32'h00000013 (NOP) and rsp_fault = 1. Otherwise rsp_instr = mem[index] and rsp_fault = 0.
- RESP: rsp_valid=1. rsp_instr, rsp_addr and rsp_fault are held stable until rsp_valid && rsp_ready.
  - On consume, if a new request is accepted on the same edge, go to WAIT or RESP as on any accept.
  - Otherwise go to IDLE.
- flush has highest priority. At an edge with flush=1:
  - state goes to IDLE, rsp_valid goes to 0, and the wait counter clears.
  - No request is accepted, because req_ready is low.
  - A response presented in that cycle is discarded even if rsp_ready=1.
- Load port: at an edge with load_we=1 and load_addr < 4*DEPTH_WORDS, mem[load_addr index] ← load_data. Out-of-range and misaligned low bits are ignored; the word index is used.
- Load/read collision: if a load write targets the same word on the edge that captures response data, the response returns the new load_data (write-first).
- Memory contents are not reset.

## Timing
- Reset (asynchronous, while reset=1):
  - state=IDLE, counter=0.
  - rsp_valid=0, rsp_instr=32'h00000013, rsp_addr=0, rsp_fault=0.
  - req_ready=0.
- After reset deasserts, req_ready=1 in the first cycle.
- Latency: a request accepted at edge E presents rsp_valid=1 in the cycle after edge E+WAIT_STATES, i.e. WAIT_STATES+1 cycles.
- Throughput with rsp_ready held high: one response per WAIT_STATES+1 cycles. With WAIT_STATES=0 this is one per cycle, back to back.
- Backpressure: with rsp_ready=0, RESP holds indefinitely and req_ready stays 0.
- Reset asserted mid-operation (WAIT or RESP): outputs return to reset values immediately and the pending request is dropped.
- flush and req_valid in the same cycle: the request is ignored. The initiator must re-present it; it is accepted the following cycle if flush=0.
- flush in IDLE: no effect other than req_ready=0 for that cycle.

## Test plan
- Load 0xAAAA0001 at address 0x0 and 0xBBBB0002 at 0x4, with WAIT_STATES=2. Request 0x4. Required: rsp_valid rises 3 cycles after accept, with rsp_instr=0xBBBB0002, rsp_addr=0x4, rsp_fault=0.
- WAIT_STATES=0, rsp_ready=1, requests 0x0, 0x4, 0x8 on consecutive cycles. Required: three consecutive rsp_valid cycles with matching data and req_ready constantly 1.
- Request 0x2, then request 4*DEPTH_WORDS. Required: both respond with rsp_fault=1 and rsp_instr=0x00000013.
- Hold rsp_ready=0 for 5 cycles while a new req_valid is pending. Required: outputs stable, req_ready=0 throughout. Raising rsp_ready consumes the response and accepts the new request on the same edge.
- Assert flush one cycle after accept (state WAIT), with req_valid=1 on 0x8 in the same cycle. Required: no rsp_valid for the flushed request, request not accepted that cycle, accepted the next cycle, and correct data returned.
- Assert reset mid-WAIT. Required: rsp_valid=0 and rsp_instr=0x00000013 immediately; previously loaded memory contents intact after reset.
